// File: rtl/pulse_indicator_pkg.sv
// rtl/pulse_indicator_pkg.sv - shared state encoding and sizing helpers for pulse_indicator
package pulse_indicator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Timer only ever holds a phase length minus one, so clog2 of the longest phase suffices.
    function automatic int tmr_width(input int on_cycles, input int gap_cycles);
        int longest;
        longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

    function automatic int pend_sat(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter shared by the ON and GAP phases
module cycle_timer #(
    parameter int W = 2
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    // Stops at zero rather than wrapping; every phase entry reloads it.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_indicator.sv
// rtl/pulse_indicator.sv - replays queued event pulses as fixed ON bursts separated by OFF gaps
module pulse_indicator
    import pulse_indicator_pkg::*;
#(
    parameter int ON_CYCLES  = 25000000,
    parameter int GAP_CYCLES = 25000000,
    parameter int CNT_W      = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             event_in,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int               TMR_W    = tmr_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_sat(CNT_W));

    state_t           state, state_next;
    logic             start;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_zero;
    logic             drop;
    logic [CNT_W-1:0] pending_next;

    cycle_timer #(.W(TMR_W)) u_timer (
        .clk_in     (clk_in),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tmr_zero)
    );

    always_comb begin
        state_next = state;
        start      = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = ON_LOAD;
        case (state)
            ST_IDLE: begin
                if (pending != '0) begin
                    state_next = ST_ON;
                    start      = 1'b1;
                    tmr_load   = 1'b1;
                end
            end
            ST_ON: begin
                if (tmr_zero) begin
                    state_next = ST_GAP;
                    tmr_load   = 1'b1;
                    tmr_value  = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (pending != '0) begin
                        state_next = ST_ON;
                        start      = 1'b1;
                        tmr_load   = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A dequeue on the same edge frees a slot, so only an unmatched event at saturation is lost.
    always_comb begin
        pending_next = pending;
        drop         = 1'b0;
        case ({event_in, start})
            2'b10: begin
                if (pending == PEND_MAX) drop = 1'b1;
                else                     pending_next = pending + CNT_W'(1);
            end
            2'b01:   pending_next = pending - CNT_W'(1);
            default: pending_next = pending;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pending  <= '0;
            overflow <= 1'b0;
            led      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            overflow <= overflow | drop;
            led      <= (state_next == ST_ON);
            busy     <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_indicator.sv
// tb/tb_pulse_indicator.sv - randomized and directed self-checking bench for pulse_indicator
module tb_pulse_indicator;

    localparam int ON    = 4;
    localparam int GAP   = 3;
    localparam int CW    = 2;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          event_in = 1'b0;
    logic          led;
    logic          busy;
    logic [CW-1:0] pending;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a burst is described by its start cycle; phase follows from elapsed time.
    int cyc;
    int m_start;
    int m_pend;
    int m_ovf;

    int cnt_led;
    int cnt_busy;
    int first_led;
    int scen_cyc;

    pulse_indicator #(
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP),
        .CNT_W      (CW)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .event_in (event_in),
        .led      (led),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        m_start = -1000;
        m_pend  = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step(input logic ev);
        int  s;
        bit  can_start;
        bit  dec;
        s         = cyc - m_start;
        can_start = (s >= ON + GAP) || (s == ON + GAP - 1);
        dec       = can_start && (m_pend > 0);
        if (ev && !dec && m_pend == SAT) m_ovf = 1;
        else                             m_pend = m_pend + int'(ev) - int'(dec);
        if (dec) m_start = cyc + 1;
        cyc++;
    endtask

    task automatic step(input logic ev);
        int s;
        @(negedge clk_in);
        s = cyc - m_start;
        chk("led",      int'(led),      (s >= 0 && s < ON) ? 1 : 0);
        chk("busy",     int'(busy),     (s >= 0 && s < ON + GAP) ? 1 : 0);
        chk("pending",  int'(pending),  m_pend);
        chk("overflow", int'(overflow), m_ovf);
        cnt_led  += int'(led);
        cnt_busy += int'(busy);
        if (led && first_led < 0) first_led = scen_cyc;
        scen_cyc++;
        event_in = ev;
        model_step(ev);
    endtask

    // Asserts rst between clock edges and expects outputs to clear before the next edge.
    task automatic do_reset();
        event_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_led",      int'(led),      0);
        chk("rst_busy",     int'(busy),     0);
        chk("rst_pending",  int'(pending),  0);
        chk("rst_overflow", int'(overflow), 0);
        @(negedge clk_in);
        rst = 1'b0;
        model_reset();
        cnt_led   = 0;
        cnt_busy  = 0;
        first_led = -1;
        scen_cyc  = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk_in);
        do_reset();

        // single event
        step(1'b1);
        repeat (20) step(1'b0);
        chk("single_led_cycles", cnt_led, ON);
        chk("single_busy_cycles", cnt_busy, ON + GAP);
        chk("single_first_led", first_led, 2);

        // back-to-back events
        do_reset();
        repeat (3) step(1'b1);
        repeat (40) step(1'b0);
        chk("b2b_led_cycles", cnt_led, 3 * ON);
        chk("b2b_busy_cycles", cnt_busy, 3 * (ON + GAP));
        chk("b2b_overflow", int'(overflow), 0);

        // saturation
        do_reset();
        repeat (5) step(1'b1);
        repeat (50) step(1'b0);
        chk("sat_led_cycles", cnt_led, 4 * ON);
        chk("sat_overflow", int'(overflow), 1);

        // event coincident with GAP->ON
        do_reset();
        step(1'b1);
        step(1'b1);
        repeat (6) step(1'b0);
        step(1'b1);
        @(posedge clk_in);
        #1;
        chk("simul_pending", int'(pending), 1);
        chk("simul_led", int'(led), 1);
        repeat (40) step(1'b0);
        chk("simul_led_cycles", cnt_led, 3 * ON);

        // async reset during the first burst with backlog of two
        do_reset();
        repeat (3) step(1'b1);
        step(1'b0);
        chk("mid_on_pending", int'(pending), 2);
        chk("mid_on_led", int'(led), 1);
        do_reset();
        repeat (20) step(1'b0);
        chk("post_rst_led_cycles", cnt_led, 0);

        // held level counts once per cycle
        do_reset();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        repeat (40) step(1'b0);
        chk("held_led_cycles", cnt_led, 3 * ON);

        // randomized traffic at several densities
        for (int d = 0; d < 3; d++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                step(($urandom_range(0, 99) < (10 + 30 * d)) ? 1'b1 : 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
